windowed_register_file: RTL and testbench
=========================================

// Module: windowed_register_file
// PURPOSE
//  SPARC integer register file with parametrised window count and internal CWP/WIM state.
//  Two combinational read ports, one write port with write-to-read bypass.
//  Hardware SAVE/RESTORE with window overflow/underflow detection, plus a post-reset
//  sequential clear. Sits in the data path between decode and ALU; the trap unit consumes
//  Window_Overflow/Window_Underflow.
// PARAMETERS
//  DATA_WIDTH  32  register width in bits
//  NWINDOWS    8   number of register windows, 2..32
//  CWP_WIDTH   5   CWP width; must satisfy 2**CWP_WIDTH >= NWINDOWS
// PORTS
//  Clock                   in   1           rising-edge clock
//  Reset_N                 in   1           asynchronous, active-low reset
//  Register_A              out  DATA_WIDTH  read port A data
//  Register_B              out  DATA_WIDTH  read port B data
//  Data_In                 in   DATA_WIDTH  write data
//  Destination_Register    in   5           architectural write index r0..r31
//  Register_A_Select       in   5           architectural read index, port A
//  Register_B_Select       in   5           architectural read index, port B
//  Load_Enable             in   1           write strobe
//  Save                    in   1           SAVE request: CWP <- (CWP-1) mod NWINDOWS
//  Restore                 in   1           RESTORE request: CWP <- (CWP+1) mod NWINDOWS
//  Cwp_Load, Cwp_In        in   1, CWP_WIDTH  direct CWP write (WRPSR)
//  Wim_Load, Wim_In        in   1, NWINDOWS   WIM write (WRWIM)
//  Current_Window_Pointer  out  CWP_WIDTH   current CWP
//  Window_Overflow         out  1           one-cycle pulse: SAVE trapped
//  Window_Underflow        out  1           one-cycle pulse: RESTORE trapped
//  Busy                    out  1           sequential clear in progress
// BEHAVIOUR
//  Storage: 8 + 16*NWINDOWS physical registers.
//  Address map:
//   - r0..r7 map to physical 0..7 (globals).
//   - r8..r31 map to 8 + ((16*CWP + (r-8)) mod (16*NWINDOWS)).
//   - The ins of window w alias the outs of window (w+1) mod NWINDOWS.
//  r0 reads as 0; writes to r0 are discarded.
//  Reads: combinational from the current CWP.
//   - Bypass: if Load_Enable and Destination_Register == Select != 0, the port returns
//     Data_In in the same cycle.
//  Write: on the rising edge when Load_Enable=1. The address is computed with the CWP
//   value held before any same-edge CWP change.
//  Window control (edge, priority order):
//   1. Cwp_Load=1: CWP <- Cwp_In. If Cwp_In >= NWINDOWS, CWP is unchanged.
//      Save/Restore are ignored. No trap.
//   2. Save=1 and Restore=1 together: no-op, no trap.
//   3. Save=1 with WIM[(CWP-1) mod N]=1: CWP unchanged, Window_Overflow=1 next cycle.
//      Otherwise CWP decrements with wrap (0 -> NWINDOWS-1).
//   4. Restore=1 with WIM[(CWP+1) mod N]=1: CWP unchanged, Window_Underflow=1 next cycle.
//      Otherwise CWP increments with wrap (NWINDOWS-1 -> 0).
//   - Trap pulses last exactly one cycle; back-to-back trapping requests give one pulse each.
//   - Wim_Load: WIM <- Wim_In on the edge. A Save/Restore on the same edge checks the old WIM.
//  FSM:
//   - CLEAR: a counter walks physical 0..8+16*NWINDOWS-1, writing 0 at one entry per cycle.
//     Busy=1. Load_Enable, Save, Restore, Cwp_Load and Wim_Load are ignored.
//     Register_A and Register_B read 0.
//   - After the last entry, move to READY. Busy=0 from the following cycle.
//   - READY: normal operation. There is no exit except reset.
//  Reset (async, Reset_N=0):
//   - state=CLEAR, counter=0, CWP=0, WIM=0.
//   - Window_Overflow=0, Window_Underflow=0, Busy=1, Register_A=Register_B=0.
//   - Reset asserted mid-clear or mid-operation restarts the clear from entry 0.
// TESTING
//  - Reset, N=8: Busy=1 for exactly 136 cycles, then 0. Every r1..r31 in every window reads 0.
//  - CWP=3, write r10=0x12345678. Read r10 -> 0x12345678. Set CWP=0 -> r10 reads 0.
//    Set CWP=3 -> r10 reads 0x12345678.
//  - CWP=3, write r8=0xAAAA5555, then Save. CWP=2, r24 reads 0xAAAA5555.
//    Restore: CWP=3, r8 reads 0xAAAA5555.
//  - Globals and r0: write r5=0xDEADBEEF at CWP=1. Reads 0xDEADBEEF at CWP=6.
//    Write r0=0xFFFFFFFF -> r0 reads 0, including via the bypass.
//  - WIM=0x01, CWP=1: Save -> Window_Overflow pulses for 1 cycle, CWP stays 1.
//    WIM=0x04: Restore -> Window_Underflow pulses, CWP stays 1.
//  - CWP=0: Save -> 7. Restore -> 0. Save+Restore together -> 0, no trap.
//    Cwp_Load with Cwp_In=9 -> CWP unchanged. Reset_N pulsed mid-clear -> Busy restarts the
//    full 136-cycle clear.

Source files
------------

// File: rtl/windowed_register_file_if.sv
// Bus between decode/ALU/trap logic and the windowed SPARC integer register file.
// The master drives reads, writes and window control; the slave returns data, CWP and status.
`timescale 1ns/1ps

interface windowed_register_file_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NWINDOWS   = 8,
    parameter int CWP_WIDTH  = 5
);
    logic [DATA_WIDTH-1:0] Register_A;
    logic [DATA_WIDTH-1:0] Register_B;
    logic [DATA_WIDTH-1:0] Data_In;
    logic [4:0]            Destination_Register;
    logic [4:0]            Register_A_Select;
    logic [4:0]            Register_B_Select;
    logic                  Load_Enable;
    logic                  Save;
    logic                  Restore;
    logic                  Cwp_Load;
    logic [CWP_WIDTH-1:0]  Cwp_In;
    logic                  Wim_Load;
    logic [NWINDOWS-1:0]   Wim_In;
    logic [CWP_WIDTH-1:0]  Current_Window_Pointer;
    logic                  Window_Overflow;
    logic                  Window_Underflow;
    logic                  Busy;

    modport master (
        output Data_In, Destination_Register, Register_A_Select, Register_B_Select,
               Load_Enable, Save, Restore, Cwp_Load, Cwp_In, Wim_Load, Wim_In,
        input  Register_A, Register_B, Current_Window_Pointer,
               Window_Overflow, Window_Underflow, Busy
    );

    modport slave (
        input  Data_In, Destination_Register, Register_A_Select, Register_B_Select,
               Load_Enable, Save, Restore, Cwp_Load, Cwp_In, Wim_Load, Wim_In,
        output Register_A, Register_B, Current_Window_Pointer,
               Window_Overflow, Window_Underflow, Busy
    );
endinterface

// File: rtl/windowed_register_file.sv
// SPARC windowed integer register file: 8 globals plus 16 registers per window, CWP/WIM
// state with SAVE/RESTORE trap detection, write-to-read bypass and a post-reset clear walk.
`timescale 1ns/1ps

module windowed_register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int NWINDOWS   = 8,
    parameter int CWP_WIDTH  = 5
) (
    input logic                    Clock,
    input logic                    Reset_N,
    windowed_register_file_if.slave bus
);

    localparam int WIN_REGS = 16 * NWINDOWS;
    localparam int NPHYS    = 8 + WIN_REGS;
    localparam int PHYS_W   = $clog2(NPHYS);

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    state_t                state_q, state_d;
    logic [PHYS_W-1:0]     clr_cnt_q, clr_cnt_d;
    logic                  busy;
    logic                  active;

    logic [CWP_WIDTH-1:0]  cwp_q, cwp_d;
    logic [NWINDOWS-1:0]   wim_q, wim_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic [CWP_WIDTH-1:0]  cwp_dec, cwp_inc;
    logic                  cwp_in_valid;

    logic [DATA_WIDTH-1:0] mem [NPHYS];
    logic                  wr_en;
    logic [PHYS_W-1:0]     wr_addr, rd_addr_a, rd_addr_b;
    logic [DATA_WIDTH-1:0] mem_a, mem_b;

    // Globals sit at 0..7; windowed registers rotate through a ring of 16*NWINDOWS entries,
    // so the ins of window w land on the outs of window w+1.
    function automatic logic [PHYS_W-1:0] phys_addr(input logic [4:0]           r,
                                                   input logic [CWP_WIDTH-1:0] cwp);
        int off;
        if (r < 5'd8) begin
            return PHYS_W'(r);
        end
        off = 16 * int'(cwp) + int'(r) - 8;
        if (off >= WIN_REGS) begin
            off = off - WIN_REGS;
        end
        return PHYS_W'(8 + off);
    endfunction

    function automatic logic wim_bit(input logic [NWINDOWS-1:0]  wim,
                                     input logic [CWP_WIDTH-1:0] idx);
        logic b;
        b = 1'b0;
        for (int i = 0; i < NWINDOWS; i++) begin
            if (int'(idx) == i) begin
                b = wim[i];
            end
        end
        return b;
    endfunction

    // ---------------------------------------------------------------- clear FSM
    always_ff @(posedge Clock or negedge Reset_N) begin
        if (!Reset_N) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
        end else begin
            // NOTE: sequential state always takes non-blocking assignments so every flop
            // samples the pre-edge values of the others, independent of block ordering.
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first; a path that skips an
        // assignment would otherwise infer a latch.
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        busy      = 1'b0;
        case (state_q)
            CLEAR: begin
                busy = 1'b1;
                if (clr_cnt_q == PHYS_W'(NPHYS - 1)) begin
                    state_d   = READY;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + PHYS_W'(1);
                end
            end
            READY: begin
                busy = 1'b0;
            end
            default: begin
                state_d = CLEAR;
                busy    = 1'b1;
            end
        endcase
    end

    assign active = (state_q == READY);

    // ---------------------------------------------------------------- storage
    assign wr_en   = active && bus.Load_Enable && (bus.Destination_Register != 5'd0);
    assign wr_addr = phys_addr(bus.Destination_Register, cwp_q);

    // NOTE: the array has no reset branch; the clear walk zeroes it one entry per cycle,
    // which keeps it mappable onto plain RAM.
    always_ff @(posedge Clock) begin
        if (!active) begin
            mem[clr_cnt_q] <= '0;
        end else if (wr_en) begin
            mem[wr_addr] <= bus.Data_In;
        end
    end

    assign rd_addr_a = phys_addr(bus.Register_A_Select, cwp_q);
    assign rd_addr_b = phys_addr(bus.Register_B_Select, cwp_q);
    assign mem_a     = mem[rd_addr_a];
    assign mem_b     = mem[rd_addr_b];

    // Bypass compares architectural indices: write and read share the current CWP.
    always_comb begin
        bus.Register_A = '0;
        bus.Register_B = '0;
        if (active && bus.Register_A_Select != 5'd0) begin
            bus.Register_A = (wr_en && bus.Destination_Register == bus.Register_A_Select)
                             ? bus.Data_In : mem_a;
        end
        if (active && bus.Register_B_Select != 5'd0) begin
            bus.Register_B = (wr_en && bus.Destination_Register == bus.Register_B_Select)
                             ? bus.Data_In : mem_b;
        end
    end

    // ---------------------------------------------------------------- window control
    assign cwp_dec      = (cwp_q == '0) ? CWP_WIDTH'(NWINDOWS - 1) : cwp_q - CWP_WIDTH'(1);
    assign cwp_inc      = (int'(cwp_q) == NWINDOWS - 1) ? '0 : cwp_q + CWP_WIDTH'(1);
    assign cwp_in_valid = (int'(bus.Cwp_In) < NWINDOWS);

    always_comb begin
        cwp_d = cwp_q;
        wim_d = wim_q;
        ovf_d = 1'b0;
        unf_d = 1'b0;
        if (active) begin
            if (bus.Wim_Load) begin
                wim_d = bus.Wim_In;
            end
            // Trap checks use wim_q, so a same-edge WIM write only affects later requests.
            if (bus.Cwp_Load) begin
                if (cwp_in_valid) begin
                    cwp_d = bus.Cwp_In;
                end
            end else if (bus.Save != bus.Restore) begin
                if (bus.Save) begin
                    if (wim_bit(wim_q, cwp_dec)) begin
                        ovf_d = 1'b1;
                    end else begin
                        cwp_d = cwp_dec;
                    end
                end else begin
                    if (wim_bit(wim_q, cwp_inc)) begin
                        unf_d = 1'b1;
                    end else begin
                        cwp_d = cwp_inc;
                    end
                end
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset_N) begin
        if (!Reset_N) begin
            cwp_q <= '0;
            wim_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            cwp_q <= cwp_d;
            wim_q <= wim_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign bus.Current_Window_Pointer = cwp_q;
    assign bus.Window_Overflow        = ovf_q;
    assign bus.Window_Underflow       = unf_q;
    assign bus.Busy                   = busy;

endmodule

// File: tb/tb_windowed_register_file.sv
// Self-checking bench for windowed_register_file: clear timing, table-driven window control,
// directed aliasing/bypass sequences and a randomized run against a window-level model.
`timescale 1ns/1ps

module tb_windowed_register_file;

    localparam int DW    = 32;
    localparam int NW    = 8;
    localparam int CW    = 5;
    localparam int CLEAR_CYCLES = 8 + 16 * NW;

    logic Clock = 1'b0;
    logic Reset_N;

    always #5 Clock = ~Clock;

    windowed_register_file_if #(.DATA_WIDTH(DW), .NWINDOWS(NW), .CWP_WIDTH(CW)) bus ();

    windowed_register_file #(.DATA_WIDTH(DW), .NWINDOWS(NW), .CWP_WIDTH(CW)) dut (
        .Clock   (Clock),
        .Reset_N (Reset_N),
        .bus     (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge Clock);
        #1;
    endtask

    task automatic idle();
        bus.Data_In              = '0;
        bus.Destination_Register = '0;
        bus.Register_A_Select    = '0;
        bus.Register_B_Select    = '0;
        bus.Load_Enable          = 1'b0;
        bus.Save                 = 1'b0;
        bus.Restore              = 1'b0;
        bus.Cwp_Load             = 1'b0;
        bus.Cwp_In               = '0;
        bus.Wim_Load             = 1'b0;
        bus.Wim_In               = '0;
    endtask

    // ---------------------------------------------------------------- reference model
    // Window-level view: each window owns 8 outs and 8 locals; its ins are the next window's outs.
    logic [31:0]   m_glob [8];
    logic [31:0]   m_out  [NW][8];
    logic [31:0]   m_loc  [NW][8];
    int            m_cwp;
    logic [NW-1:0] m_wim;

    task automatic m_reset();
        for (int i = 0; i < 8; i++) m_glob[i] = '0;
        for (int w = 0; w < NW; w++)
            for (int i = 0; i < 8; i++) begin
                m_out[w][i] = '0;
                m_loc[w][i] = '0;
            end
        m_cwp = 0;
        m_wim = '0;
    endtask

    function automatic logic [31:0] m_read(input int r);
        if (r == 0)       return '0;
        else if (r < 8)   return m_glob[r];
        else if (r < 16)  return m_out[m_cwp][r - 8];
        else if (r < 24)  return m_loc[m_cwp][r - 16];
        else              return m_out[(m_cwp + 1) % NW][r - 24];
    endfunction

    task automatic m_write(input int r, input logic [31:0] d);
        if (r == 0)       ;
        else if (r < 8)   m_glob[r] = d;
        else if (r < 16)  m_out[m_cwp][r - 8] = d;
        else if (r < 24)  m_loc[m_cwp][r - 16] = d;
        else              m_out[(m_cwp + 1) % NW][r - 24] = d;
    endtask

    // ---------------------------------------------------------------- helpers
    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 32'(bus.Busy), 32'd1);
        check({tag, "_a"}, bus.Register_A, 32'd0);
        check({tag, "_b"}, bus.Register_B, 32'd0);
        check({tag, "_cwp"}, 32'(bus.Current_Window_Pointer), 32'd0);
        check({tag, "_ovf"}, 32'(bus.Window_Overflow), 32'd0);
        check({tag, "_unf"}, 32'(bus.Window_Underflow), 32'd0);
    endtask

    // Counts Busy cycles from reset release; optionally pokes ignored commands mid-clear.
    task automatic run_clear(input string tag, input bit poke);
        int n;
        n = 0;
        while (bus.Busy === 1'b1 && n < 1000) begin
            if (poke && n == 5) begin
                bus.Load_Enable          = 1'b1;
                bus.Destination_Register = 5'd16;
                bus.Data_In              = 32'hFFFF_FFFF;
                bus.Register_A_Select    = 5'd16;
                bus.Save                 = 1'b1;
                bus.Wim_Load             = 1'b1;
                bus.Wim_In               = '1;
                #1;
                check({tag, "_clear_read"}, bus.Register_A, 32'd0);
            end
            if (poke && n == 15) idle();
            n++;
            cycle();
        end
        idle();
        check({tag, "_clear_len"}, 32'(n), 32'(CLEAR_CYCLES));
    endtask

    task automatic set_cwp(input int w);
        bus.Cwp_Load = 1'b1;
        bus.Cwp_In   = CW'(w);
        cycle();
        bus.Cwp_Load = 1'b0;
    endtask

    task automatic write_reg(input int r, input logic [31:0] d);
        bus.Load_Enable          = 1'b1;
        bus.Destination_Register = 5'(r);
        bus.Data_In              = d;
        cycle();
        bus.Load_Enable          = 1'b0;
    endtask

    task automatic read_a(input int r, output logic [31:0] v);
        bus.Register_A_Select = 5'(r);
        #1;
        v = bus.Register_A;
    endtask

    task automatic pulse_save_restore(input bit s, input bit r);
        bus.Save    = s;
        bus.Restore = r;
        cycle();
        bus.Save    = 1'b0;
        bus.Restore = 1'b0;
    endtask

    // ---------------------------------------------------------------- vector table
    typedef struct {
        int save;
        int restore;
        int cwp_load;
        int cwp_in;
        int wim_load;
        int wim_in;
        int exp_cwp;
        int exp_ovf;
        int exp_unf;
    } vec_t;

    vec_t vecs [22];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;

        //            sav rst cwl cwi wml wmi  cwp ovf unf
        vecs[0]  = '{0,  0,  1,  0,  0,  0,    0,  0,  0};
        vecs[1]  = '{1,  0,  0,  0,  0,  0,    7,  0,  0};
        vecs[2]  = '{0,  1,  0,  0,  0,  0,    0,  0,  0};
        vecs[3]  = '{1,  1,  0,  0,  0,  0,    0,  0,  0};
        vecs[4]  = '{0,  0,  1,  9,  0,  0,    0,  0,  0};
        vecs[5]  = '{0,  0,  1,  1,  0,  0,    1,  0,  0};
        vecs[6]  = '{0,  0,  0,  0,  1,  'h01, 1,  0,  0};
        vecs[7]  = '{1,  0,  0,  0,  0,  0,    1,  1,  0};
        vecs[8]  = '{1,  0,  0,  0,  0,  0,    1,  1,  0};
        vecs[9]  = '{0,  0,  0,  0,  0,  0,    1,  0,  0};
        vecs[10] = '{1,  0,  1,  5,  1,  'h04, 5,  0,  0};
        vecs[11] = '{0,  0,  1,  1,  0,  0,    1,  0,  0};
        vecs[12] = '{0,  1,  0,  0,  0,  0,    1,  0,  1};
        vecs[13] = '{0,  0,  0,  0,  0,  0,    1,  0,  0};
        vecs[14] = '{1,  0,  0,  0,  1,  'h01, 0,  0,  0};
        vecs[15] = '{0,  1,  0,  0,  0,  0,    1,  0,  0};
        vecs[16] = '{1,  0,  0,  0,  0,  0,    1,  1,  0};
        vecs[17] = '{1,  1,  1,  7,  0,  0,    7,  0,  0};
        vecs[18] = '{0,  1,  0,  0,  0,  0,    7,  0,  1};
        vecs[19] = '{0,  0,  1,  8,  0,  0,    7,  0,  0};
        vecs[20] = '{0,  1,  0,  0,  1,  'h00, 7,  0,  1};
        vecs[21] = '{0,  1,  0,  0,  0,  0,    0,  0,  0};

        // ------------------------------------------------ reset and clear
        idle();
        Reset_N = 1'b0;
        #3;
        check_reset_outputs("rst0");
        cycle();
        cycle();
        Reset_N = 1'b1;
        run_clear("rst0", 1'b1);
        check("post_clear_cwp", 32'(bus.Current_Window_Pointer), 32'd0);
        check("post_clear_busy", 32'(bus.Busy), 32'd0);

        for (int w = 0; w < NW; w++) begin
            set_cwp(w);
            for (int r = 1; r < 32; r++) begin
                bus.Register_A_Select = 5'(r);
                bus.Register_B_Select = 5'(31 - r + 1);
                #1;
                check($sformatf("zero_w%0d_a_r%0d", w, r), bus.Register_A, 32'd0);
                check($sformatf("zero_w%0d_b_r%0d", w, 32 - r), bus.Register_B, 32'd0);
            end
        end
        idle();

        // ------------------------------------------------ table-driven window control
        for (int i = 0; i < $size(vecs); i++) begin
            bus.Save     = vecs[i].save[0];
            bus.Restore  = vecs[i].restore[0];
            bus.Cwp_Load = vecs[i].cwp_load[0];
            bus.Cwp_In   = CW'(vecs[i].cwp_in);
            bus.Wim_Load = vecs[i].wim_load[0];
            bus.Wim_In   = NW'(vecs[i].wim_in);
            cycle();
            check($sformatf("vec%0d_cwp", i), 32'(bus.Current_Window_Pointer), 32'(vecs[i].exp_cwp));
            check($sformatf("vec%0d_ovf", i), 32'(bus.Window_Overflow), 32'(vecs[i].exp_ovf));
            check($sformatf("vec%0d_unf", i), 32'(bus.Window_Underflow), 32'(vecs[i].exp_unf));
        end
        idle();

        // ------------------------------------------------ directed: window-private register
        set_cwp(3);
        write_reg(10, 32'h1234_5678);
        read_a(10, v);  check("r10_w3", v, 32'h1234_5678);
        set_cwp(0);
        read_a(10, v);  check("r10_w0", v, 32'd0);
        set_cwp(3);
        read_a(10, v);  check("r10_w3_again", v, 32'h1234_5678);

        // ------------------------------------------------ directed: outs/ins aliasing
        write_reg(8, 32'hAAAA_5555);
        pulse_save_restore(1'b1, 1'b0);
        check("save_cwp", 32'(bus.Current_Window_Pointer), 32'd2);
        read_a(24, v);  check("alias_r24_w2", v, 32'hAAAA_5555);
        pulse_save_restore(1'b0, 1'b1);
        check("restore_cwp", 32'(bus.Current_Window_Pointer), 32'd3);
        read_a(8, v);   check("alias_r8_w3", v, 32'hAAAA_5555);

        // ------------------------------------------------ directed: globals, r0 and bypass
        set_cwp(1);
        write_reg(5, 32'hDEAD_BEEF);
        set_cwp(6);
        read_a(5, v);   check("global_r5_w6", v, 32'hDEAD_BEEF);

        bus.Load_Enable          = 1'b1;
        bus.Destination_Register = 5'd0;
        bus.Data_In              = 32'hFFFF_FFFF;
        bus.Register_A_Select    = 5'd0;
        #1;
        check("r0_bypass", bus.Register_A, 32'd0);
        cycle();
        bus.Load_Enable = 1'b0;
        read_a(0, v);   check("r0_after_write", v, 32'd0);

        bus.Load_Enable          = 1'b1;
        bus.Destination_Register = 5'd12;
        bus.Data_In              = 32'h0BAD_F00D;
        bus.Register_B_Select    = 5'd12;
        bus.Register_A_Select    = 5'd13;
        #1;
        check("bypass_b", bus.Register_B, 32'h0BAD_F00D);
        check("no_bypass_a", bus.Register_A, 32'd0);
        cycle();
        idle();
        bus.Register_B_Select = 5'd12;
        #1;
        check("bypass_written", bus.Register_B, 32'h0BAD_F00D);
        idle();

        // ------------------------------------------------ reset during clear restarts it
        Reset_N = 1'b0;
        #2;
        check_reset_outputs("rst1");
        cycle();
        Reset_N = 1'b1;
        repeat (50) cycle();
        check("mid_clear_busy", 32'(bus.Busy), 32'd1);
        Reset_N = 1'b0;
        #2;
        check_reset_outputs("rst2");
        cycle();
        Reset_N = 1'b1;
        run_clear("rst2", 1'b0);

        // ------------------------------------------------ randomized run against the model
        m_reset();
        for (int c = 0; c < 1500; c++) begin
            logic        le, sv, rs, cl, wl;
            int          dst, sa, sb, ci;
            logic [31:0] din, exp_a, exp_b;
            logic [NW-1:0] wi;
            int          dec, inc, exp_ovf, exp_unf;

            le  = ($urandom_range(0, 1) == 1);
            sv  = ($urandom_range(0, 3) == 0);
            rs  = ($urandom_range(0, 3) == 0);
            cl  = ($urandom_range(0, 7) == 0);
            wl  = ($urandom_range(0, 9) == 0);
            ci  = $urandom_range(0, 11);
            wi  = NW'($urandom & $urandom);
            dst = $urandom_range(0, 31);
            sa  = ($urandom_range(0, 1) == 1) ? dst : $urandom_range(0, 31);
            sb  = $urandom_range(0, 31);
            din = $urandom;

            bus.Load_Enable          = le;
            bus.Destination_Register = 5'(dst);
            bus.Data_In              = din;
            bus.Register_A_Select    = 5'(sa);
            bus.Register_B_Select    = 5'(sb);
            bus.Save                 = sv;
            bus.Restore              = rs;
            bus.Cwp_Load             = cl;
            bus.Cwp_In               = CW'(ci);
            bus.Wim_Load             = wl;
            bus.Wim_In               = wi;
            #1;
            exp_a = (sa != 0 && le && dst == sa) ? din : m_read(sa);
            exp_b = (sb != 0 && le && dst == sb) ? din : m_read(sb);
            check($sformatf("rnd%0d_a", c), bus.Register_A, exp_a);
            check($sformatf("rnd%0d_b", c), bus.Register_B, exp_b);
            cycle();

            if (le) m_write(dst, din);
            exp_ovf = 0;
            exp_unf = 0;
            dec = (m_cwp + NW - 1) % NW;
            inc = (m_cwp + 1) % NW;
            if (cl) begin
                if (ci < NW) m_cwp = ci;
            end else if (sv && !rs) begin
                if (m_wim[dec]) exp_ovf = 1; else m_cwp = dec;
            end else if (rs && !sv) begin
                if (m_wim[inc]) exp_unf = 1; else m_cwp = inc;
            end
            if (wl) m_wim = wi;

            check($sformatf("rnd%0d_cwp", c), 32'(bus.Current_Window_Pointer), 32'(m_cwp));
            check($sformatf("rnd%0d_ovf", c), 32'(bus.Window_Overflow), 32'(exp_ovf));
            check($sformatf("rnd%0d_unf", c), 32'(bus.Window_Underflow), 32'(exp_unf));
        end
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
